// File: rtl/event_readout_if.sv
// event_readout_if: beat stream from event_readout to the downstream consumer.
// Signals:
//   out_data   readout beat
//   out_valid  out_data holds a valid beat
//   out_last   final beat of an event frame
//   out_ready  consumer accepts the beat when out_valid and out_ready are high
// Modports: master (producer side), slave (consumer side).
interface event_readout_if #(
  parameter int W_OUT = 32
);
  logic [W_OUT-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/event_readout.sv
// event_readout: captures a complete event on the rising edge of trigger and
// streams it out as one header beat {16'hA5A5, evt_cnt} followed by
// N_CH*W_EV/W_OUT data beats, word 0 first, least-significant slice first.
// Ports:
//   clk_500      sampling/readout clock, rising edge
//   rst_n        asynchronous active-low reset
//   trigger      event-complete level; a rising edge starts a frame
//   evento       N_CH event words of W_EV bits, copied when a frame starts
//   stream       valid/ready beat output (out_data, out_valid, out_last, out_ready)
//   event_saved  one-cycle pulse after the last beat of a frame is accepted
//   busy         high whenever a frame is in progress
//   dropped      saturating count of trigger edges ignored while busy
// W_EV must be an integer multiple of W_OUT, and W_OUT at least 32 so the
// header fits in one beat.
module event_readout #(
  parameter int N_CH  = 16,
  parameter int W_EV  = 64,
  parameter int W_OUT = 32
) (
  input  logic                       clk_500,
  input  logic                       rst_n,
  input  logic                       trigger,
  input  logic [N_CH-1:0][W_EV-1:0]  evento,
  event_readout_if.master            stream,
  output logic                       event_saved,
  output logic                       busy,
  output logic [15:0]                dropped
);

  localparam int N_BEATS = N_CH * W_EV / W_OUT;
  localparam int BW      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(N_BEATS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_DATA   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [15:0] HDR_TAG = 16'hA5A5;

  logic [1:0]                   state;
  logic [N_BEATS-1:0][W_OUT-1:0] shadow;   // captured event, viewed as beats
  logic [BW-1:0]                beat_idx;
  logic [15:0]                  evt_cnt;
  logic                         trig_q;
  logic                         armed;
  logic                         trig_edge;
  logic                         accept;
  logic                         last_beat;

  // armed stays low for the first cycle after reset so that a trigger already
  // high at reset release is taken as the previous level, not as an edge.
  assign trig_edge = trigger & ~trig_q & armed;
  assign accept    = stream.out_valid & stream.out_ready;
  assign last_beat = (beat_idx == LAST_BEAT);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the clock edge, independent of block order.
  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      trig_q <= trigger;
      armed  <= 1'b1;
    end
  end

  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      beat_idx <= '0;
      evt_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (trig_edge) begin
            beat_idx <= '0;
            state    <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (accept) state <= S_DATA;
        end
        S_DATA: begin
          if (accept) begin
            if (last_beat) begin
              evt_cnt <= evt_cnt + 16'd1;   // wraps naturally at 16'hFFFF
              state   <= S_DONE;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Any edge outside IDLE (including the DONE cycle) is ignored and counted.
  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      dropped <= '0;
    end else if (trig_edge && (state != S_IDLE) && (dropped != 16'hFFFF)) begin
      dropped <= dropped + 16'd1;
    end
  end

  // NOTE: this wide register is reset on purpose so a frame abandoned by reset
  // leaves no stale event data behind; plain data storage normally is not reset.
  always_ff @(posedge clk_500 or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if ((state == S_IDLE) && trig_edge) begin
      shadow <= evento;
    end
  end

  // All outputs decode registered state only, so out_valid never depends on
  // out_ready and everything drops to zero as soon as reset asserts.
  // NOTE: out_data gets a default first so no path through the case leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    stream.out_data = '0;
    case (state)
      S_HEADER: stream.out_data = W_OUT'({HDR_TAG, evt_cnt});
      S_DATA:   stream.out_data = shadow[beat_idx];
      default:  stream.out_data = '0;
    endcase
  end

  assign stream.out_valid = (state == S_HEADER) || (state == S_DATA);
  assign stream.out_last  = (state == S_DATA) && last_beat;
  assign event_saved      = (state == S_DONE);
  assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_event_readout.sv
// tb_event_readout: self-checking bench for event_readout.
// A table of per-cycle vectors covers frame start, stalls, dropped edges and
// reset; hand sequences cover asynchronous reset mid-frame and counter wrap;
// randomized frames are checked against a queue of expected beats built from
// the captured event words.
`timescale 1ns/1ps
module tb_event_readout;

  localparam int N_CH    = 16;
  localparam int W_EV    = 64;
  localparam int W_OUT   = 32;
  localparam int N_BEATS = N_CH * W_EV / W_OUT;
  localparam int SPW     = W_EV / W_OUT;

  typedef logic [N_CH-1:0][W_EV-1:0] ev_t;

  typedef struct {
    logic        rst_n;
    logic        trig;
    logic        rdy;
    logic        valid;
    logic        last;
    logic        saved;
    logic        busy;
    logic [31:0] data;
    logic [15:0] drop;
  } vec_t;

  logic        clk_500 = 1'b0;
  logic        rst_n   = 1'b0;
  logic        trigger = 1'b0;
  ev_t         evento  = '0;
  logic        event_saved;
  logic        busy;
  logic [15:0] dropped;

  event_readout_if #(.W_OUT(W_OUT)) stream ();

  event_readout #(
    .N_CH  (N_CH),
    .W_EV  (W_EV),
    .W_OUT (W_OUT)
  ) dut (
    .clk_500     (clk_500),
    .rst_n       (rst_n),
    .trigger     (trigger),
    .evento      (evento),
    .stream      (stream),
    .event_saved (event_saved),
    .busy        (busy),
    .dropped     (dropped)
  );

  always #5 clk_500 = ~clk_500;

  int checks = 0;
  int errors = 0;

  // Reference model state: frame counter and dropped-edge counter.
  logic [15:0] m_cnt     = '0;
  logic [15:0] m_dropped = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t pattern();
    ev_t v;
    for (int k = 0; k < N_CH; k++) v[k] = {32'(2 * k + 1), 32'(2 * k)};
    return v;
  endfunction

  function automatic ev_t rand_ev();
    ev_t v;
    for (int k = 0; k < N_CH; k++)
      for (int j = 0; j < W_EV / 32; j++) v[k][j*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // Runs one frame starting from IDLE. ready_pct sets out_ready probability,
  // drops is the number of extra trigger pulses to issue mid-frame, mutate
  // scrambles evento every cycle after capture, done_pulse raises trigger in
  // the DONE cycle. Returns at the cycle where event_saved is high.
  task automatic run_frame(input ev_t ev, input int ready_pct, input int drops,
                           input bit mutate, input bit done_pulse);
    logic [W_OUT-1:0] exp_q[$];
    logic [W_OUT-1:0] exp_beat;
    logic [W_OUT-1:0] held_data;
    logic             held_last;
    logic             v;
    logic             l;
    logic [W_OUT-1:0] d;
    bit               stalled;
    bit               finished;
    bit               rdy;
    int               cyc;
    int               drops_left;

    @(negedge clk_500);
    check("idle flags", {stream.out_valid, event_saved, busy}, 3'b000);
    check("idle dropped", dropped, m_dropped);
    if (trigger) begin
      trigger = 1'b0;
      @(negedge clk_500);
    end

    exp_q.push_back(W_OUT'({16'hA5A5, m_cnt}));
    for (int w = 0; w < N_CH; w++)
      for (int s = 0; s < SPW; s++) exp_q.push_back(ev[w][s*W_OUT +: W_OUT]);

    evento = ev;
    trigger = 1'b1;
    stream.out_ready = ($urandom_range(0, 99) < ready_pct);

    cyc = 0; stalled = 0; finished = 0; drops_left = drops;
    held_data = '0; held_last = 1'b0;
    while (!finished && cyc < 2000) begin
      @(negedge clk_500);
      cyc++;
      if (mutate) evento = rand_ev();
      v = stream.out_valid; d = stream.out_data; l = stream.out_last;
      if (stalled) check("stall hold", {v, l, d}, {1'b1, held_last, held_data});
      rdy = ($urandom_range(0, 99) < ready_pct);
      stream.out_ready = rdy;
      if (v && rdy) begin
        if (exp_q.size() == 0) begin
          check("extra beat", 1'b1, 1'b0);
        end else begin
          exp_beat = exp_q.pop_front();
          check($sformatf("beat %0d", N_BEATS - exp_q.size()), d, exp_beat);
          check("last flag", l, exp_q.size() == 0);
          if (exp_q.size() == 0) finished = 1;
        end
      end
      stalled = v && !rdy;
      held_data = d; held_last = l;
      if (trigger) begin
        trigger = 1'b0;
      end else if (drops_left > 0 && v && !finished && $urandom_range(0, 1) == 0) begin
        trigger = 1'b1;
        drops_left--;
        m_dropped = sat_inc(m_dropped);
      end
    end
    if (!finished) check("frame timeout", 1'b0, 1'b1);
    if (finished && ready_pct >= 100) check("frame latency", cyc, N_BEATS + 1);

    @(negedge clk_500);
    trigger = 1'b0;
    check("done flags", {event_saved, stream.out_valid, stream.out_last, busy}, 4'b1001);
    check("frame dropped", dropped, m_dropped);
    m_cnt = m_cnt + 16'd1;
    if (done_pulse) begin
      trigger = 1'b1;
      m_dropped = sat_inc(m_dropped);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  vec_t tbl[12];
  bit   found;
  bit   saw_saved;

  initial begin
    // evt: rst  trg  rdy  valid last saved busy  data          dropped
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0000, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA5A5_0000, 16'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0,         16'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0,         16'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1,         16'd1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2,         16'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2,         16'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd3,         16'd2};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         16'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         16'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         16'd0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,         16'd0};

    // Reset state, with trigger already high when reset is released.
    stream.out_ready = 1'b0;
    trigger = 1'b1;
    #12;
    check("reset flags", {stream.out_valid, stream.out_last, event_saved, busy}, 4'b0000);
    check("reset data", stream.out_data, 32'd0);
    check("reset dropped", dropped, 16'd0);
    @(negedge clk_500);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_500);
    check("no edge at release", {busy, stream.out_valid}, 2'b00);
    check("no drop at release", dropped, 16'd0);
    trigger = 1'b0;

    // Table-driven cycle vectors.
    evento = pattern();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_500);
      rst_n = tbl[i].rst_n;
      trigger = tbl[i].trig;
      stream.out_ready = tbl[i].rdy;
      @(posedge clk_500);
      #2;
      check($sformatf("vec%0d flags", i),
            {stream.out_valid, stream.out_last, event_saved, busy},
            {tbl[i].valid, tbl[i].last, tbl[i].saved, tbl[i].busy});
      check($sformatf("vec%0d data", i), stream.out_data, tbl[i].data);
      check($sformatf("vec%0d dropped", i), dropped, tbl[i].drop);
    end

    // Asynchronous reset at data beat 10 abandons the frame.
    @(negedge clk_500);
    evento = pattern(); trigger = 1'b1; stream.out_ready = 1'b1;
    @(negedge clk_500); trigger = 1'b0;
    @(negedge clk_500); trigger = 1'b1;
    @(negedge clk_500); trigger = 1'b0;
    found = 0; saw_saved = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk_500);
      if (event_saved) saw_saved = 1;
      if (stream.out_valid && stream.out_data == 32'd10) found = 1;
    end
    check("reach beat 10", found, 1'b1);
    check("dropped before reset", dropped, 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset flags", {stream.out_valid, stream.out_last, event_saved, busy}, 4'b0000);
    check("mid reset data", stream.out_data, 32'd0);
    check("mid reset dropped", dropped, 16'd0);
    repeat (2) begin
      @(negedge clk_500);
      if (event_saved) saw_saved = 1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk_500);
      if (event_saved) saw_saved = 1;
    end
    check("no saved after reset", saw_saved, 1'b0);
    m_cnt = '0; m_dropped = '0;

    // Directed frames: back-pressure free with latency, random stalls,
    // three dropped edges, evento changing after capture, edge in DONE.
    run_frame(pattern(), 100, 0, 1'b0, 1'b0);
    run_frame(pattern(), 50,  0, 1'b0, 1'b0);
    run_frame(pattern(), 100, 3, 1'b0, 1'b0);
    run_frame(pattern(), 100, 0, 1'b1, 1'b0);
    run_frame(rand_ev(), 100, 0, 1'b0, 1'b1);
    run_frame(rand_ev(), 100, 0, 1'b0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 6; f++)
      run_frame(rand_ev(), 50, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Frame counter wrap: header FFFF, then 0000.
    @(negedge clk_500);
    force dut.evt_cnt = 16'hFFFF;
    @(negedge clk_500);
    release dut.evt_cnt;
    m_cnt = 16'hFFFF;
    run_frame(pattern(), 100, 0, 1'b0, 1'b0);
    run_frame(pattern(), 100, 0, 1'b0, 1'b0);

    // dropped saturates at FFFF.
    @(negedge clk_500);
    force dut.dropped = 16'hFFFD;
    @(negedge clk_500);
    release dut.dropped;
    m_dropped = 16'hFFFD;
    run_frame(rand_ev(), 100, 3, 1'b0, 1'b1);
    run_frame(rand_ev(), 50, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_readout.md
EVENT_READOUT -- requirements
Module: event_readout

Interface
REQ-001 Parameter N_CH, default 16, number of event words captured per event.
REQ-002 Parameter W_EV, default 64, width of each event word in bits.
REQ-003 Parameter W_OUT, default 32, output beat width; W_EV SHALL be an integer multiple of W_OUT.
REQ-004 clk_500  input  1  single sampling/readout clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 trigger  input  1  level from the event trigger; a rising edge marks evento as complete.
REQ-007 evento  input  N_CH x W_EV  captured event from the sampler, stable on and after the trigger rising edge.
REQ-008 out_data  output  W_OUT  readout beat.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.
REQ-011 out_last  output  1  marks the final beat of an event frame.
REQ-012 event_saved  output  1  one-cycle pulse after the last beat of a frame is accepted; returned to the sampler to release its buffer.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 dropped  output  16  count of trigger rising edges ignored while busy.

Function
REQ-015 Trigger edge detection SHALL register trigger once; an edge is trigger high with the previous sample low.
REQ-016 States SHALL be IDLE, HEADER, DATA and DONE.
REQ-017 IDLE -> HEADER on a trigger edge; in the same cycle, all of evento SHALL be copied into an internal shadow register.
REQ-018 HEADER SHALL present out_data = {16'hA5A5, evt_cnt[15:0]} with out_valid high; on handshake, go to DATA.
REQ-019 DATA SHALL emit N_CH*W_EV/W_OUT beats from the shadow register in order word 0..N_CH-1, least-significant slice first; with defaults: evento[0][31:0], evento[0][63:32], ..., evento[15][63:32], which is 32 beats.
REQ-020 out_last SHALL be high only on the final DATA beat; on handshake of that beat, go to DONE.
REQ-021 DONE SHALL last exactly one cycle with event_saved high and out_valid low, then go to IDLE.
REQ-022 While out_valid is high and out_ready is low, out_data, out_last and the beat index SHALL hold unchanged.
REQ-023 out_valid SHALL not depend combinationally on out_ready.
REQ-024 With out_ready held high, a frame SHALL complete in 1 + N_CH*W_EV/W_OUT cycles from HEADER entry, and event_saved SHALL follow in the next cycle.
REQ-025 evt_cnt SHALL be 16 bits, SHALL increment on entry to DONE, and SHALL wrap from 16'hFFFF to 0.
REQ-026 A trigger edge in any state other than IDLE SHALL not disturb the frame and SHALL increment dropped, saturating at 16'hFFFF.
REQ-027 A trigger edge in the DONE cycle SHALL count as dropped; an edge in the first IDLE cycle after DONE SHALL start a new frame.
REQ-028 Changes on evento after capture SHALL not affect the frame in progress.

Reset
REQ-029 When rst_n is low, the block SHALL immediately enter IDLE and drive out_valid=0, out_last=0, out_data=0, event_saved=0, busy=0, dropped=0 and evt_cnt=0; the shadow register and the edge-detect flop SHALL clear.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without an event_saved pulse.
REQ-031 Release of rst_n with trigger already high SHALL not produce an edge.

Verification
REQ-032 Load evento[k] = {32'(2k+1), 32'(2k)}, pulse trigger, hold out_ready=1: expect header A5A5_0000, then beats 0,1,...,31 on consecutive cycles, out_last on beat 31, and event_saved one cycle later.
REQ-033 Toggle out_ready randomly 50%: expect the same 33-beat sequence, with no beat lost or duplicated and out_data stable during stalls.
REQ-034 Pulse trigger three times during a frame: expect dropped=3 and the frame unchanged; the second frame header shows evt_cnt=1.
REQ-035 Change evento on the cycle after the trigger edge: expect the frame to carry the originally captured values.
REQ-036 Assert rst_n low at beat 10: expect all outputs to be 0 in that cycle, no event_saved, and a clean frame on the next trigger with header A5A5_0000.
REQ-037 Run 65536 frames: expect the header counter to wrap to 0000 on frame 65537.
